// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: two-master, non-pipelined req/gnt/rvalid memory port arbiter with a response watchdog; ports clk/reset (sync, active-high), m0_*/m1_* master sides, s_* slave side, bus_err timeout pulse; `ARB_ROUND_ROBIN_EN selects round-robin over fixed M0 priority
module mem_bus_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int TIMEOUT = 255,
  parameter logic [DATA_W-1:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                m0_req,
  input  logic                m0_we,
  input  logic [DATA_W/8-1:0] m0_be,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W-1:0]   m0_wdata,
  output logic                m0_gnt,
  output logic                m0_rvalid,
  output logic [DATA_W-1:0]   m0_rdata,
  input  logic                m1_req,
  input  logic                m1_we,
  input  logic [DATA_W/8-1:0] m1_be,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m1_wdata,
  output logic                m1_gnt,
  output logic                m1_rvalid,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                s_req,
  output logic                s_we,
  output logic [DATA_W/8-1:0] s_be,
  output logic [ADDR_W-1:0]   s_addr,
  output logic [DATA_W-1:0]   s_wdata,
  input  logic                s_gnt,
  input  logic                s_rvalid,
  input  logic [DATA_W-1:0]   s_rdata,
  output logic                bus_err
);
  localparam int WD_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  state_t          r_state, w_next;
  logic            r_owner, r_last;
  logic [WD_W-1:0] r_wd;
  logic            w_winner, w_gnt, w_rv;
  logic [DATA_W-1:0] w_rd;
`ifdef ARB_ROUND_ROBIN_EN
  assign w_winner = (m0_req && m1_req) ? ~r_last : m1_req;
`else
  // With no request the winner is a don't-care; falling back to last owner keeps r_last observable.
  assign w_winner = m0_req ? 1'b0 : (m1_req ? 1'b1 : r_last);
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_owner <= 1'b0;
      r_last  <= 1'b1;
      r_wd    <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && (m0_req || m1_req)) r_owner <= w_winner;
      if (r_state == REQ && s_gnt) begin
        r_last <= r_owner;
        r_wd   <= '0;
      end else if (r_state == WAIT) r_wd <= r_wd + 1'b1;
    end
  end
  always_comb begin
    w_next  = r_state;
    s_req   = 1'b0;
    s_we    = 1'b0;
    s_be    = '0;
    s_addr  = '0;
    s_wdata = '0;
    w_gnt   = 1'b0;
    w_rv    = 1'b0;
    w_rd    = '0;
    bus_err = 1'b0;
    case (r_state)
      IDLE: w_next = (m0_req || m1_req) ? REQ : IDLE;
      REQ: begin
        s_req   = 1'b1;
        s_we    = r_owner ? m1_we    : m0_we;
        s_be    = r_owner ? m1_be    : m0_be;
        s_addr  = r_owner ? m1_addr  : m0_addr;
        s_wdata = r_owner ? m1_wdata : m0_wdata;
        w_gnt   = s_gnt;
        w_next  = s_gnt ? WAIT : REQ;
      end
      WAIT: begin
        // A real response beats a watchdog expiry landing in the same cycle.
        if (s_rvalid) begin
          w_rv   = 1'b1;
          w_rd   = s_rdata;
          w_next = IDLE;
        end else if (TIMEOUT != 0 && r_wd == WD_LAST) begin
          w_rv    = 1'b1;
          w_rd    = ERR_DATA;
          bus_err = 1'b1;
          w_next  = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end
  assign m0_gnt    = w_gnt & ~r_owner;
  assign m1_gnt    = w_gnt & r_owner;
  assign m0_rvalid = w_rv & ~r_owner;
  assign m1_rvalid = w_rv & r_owner;
  assign m0_rdata  = r_owner ? '0 : w_rd;
  assign m1_rdata  = r_owner ? w_rd : '0;
endmodule
